// File: rtl/dt_ridge_pack_if.sv
// Bus bundle for dt_ridge_pack: start/busy/done control, result RAM read port,
// skeleton memory write port and the optional ridge counter.
interface dt_ridge_pack_if;
    logic        start;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        skl_wr;
    logic [9:0]  skl_addr;
    logic [15:0] skl_do;
    logic        busy;
    logic        done;
    logic [14:0] ridge_cnt;

    modport master (
        input  start, res_di,
        output res_rd, res_addr, skl_wr, skl_addr, skl_do, busy, done, ridge_cnt
    );

    modport slave (
        output start, res_di,
        input  res_rd, res_addr, skl_wr, skl_addr, skl_do, busy, done, ridge_cnt
    );
endinterface

// File: rtl/dt_ridge_pack.sv
// Scans the 128x128 distance map, flags ridge pixels (non-zero, >= all 8 neighbours)
// and packs them MSB-first, 16 per word. Optional ridge counter: DT_RIDGE_CNT_EN.
module dt_ridge_pack (
    input  logic            clk,
    input  logic            reset,
    dt_ridge_pack_if.master bus
);
    typedef enum logic [2:0] {IDLE, CENTER, NBR, WRITE, FIN} state_t;

    state_t      state_reg, state_next;
    logic [13:0] p_reg, p_next;
    logic [2:0]  k_reg, k_next;
    logic [7:0]  c_reg, c_next;
    logic [15:0] word_reg, word_next;

    logic [6:0]  x, y;
    logic        nbr_in;
    logic [13:0] nbr_addr;
    logic [7:0]  nbr_val;
    logic        fin;
    logic        flag;

    assign x = p_reg[6:0];
    assign y = p_reg[13:7];

    // Neighbour k in NW,N,NE,W,E,SW,S,SE order; out-of-image ones never form an address.
    always_comb begin
        nbr_in   = 1'b0;
        nbr_addr = p_reg;
        case (k_reg)
            3'd0: begin nbr_in = (x != 7'd0)   && (y != 7'd0);   nbr_addr = p_reg - 14'd129; end
            3'd1: begin nbr_in = (y != 7'd0);                    nbr_addr = p_reg - 14'd128; end
            3'd2: begin nbr_in = (x != 7'd127) && (y != 7'd0);   nbr_addr = p_reg - 14'd127; end
            3'd3: begin nbr_in = (x != 7'd0);                    nbr_addr = p_reg - 14'd1;   end
            3'd4: begin nbr_in = (x != 7'd127);                  nbr_addr = p_reg + 14'd1;   end
            3'd5: begin nbr_in = (x != 7'd0)   && (y != 7'd127); nbr_addr = p_reg + 14'd127; end
            3'd6: begin nbr_in = (y != 7'd127);                  nbr_addr = p_reg + 14'd128; end
            default: begin nbr_in = (x != 7'd127) && (y != 7'd127); nbr_addr = p_reg + 14'd129; end
        endcase
        if (!nbr_in) begin
            nbr_addr = p_reg;
        end
        nbr_val = nbr_in ? bus.res_di : 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            k_reg     <= '0;
            c_reg     <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            p_reg     <= p_next;
            k_reg     <= k_next;
            c_reg     <= c_next;
            word_reg  <= word_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        k_next     = k_reg;
        c_next     = c_reg;
        word_next  = word_reg;
        fin        = 1'b0;
        flag       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    p_next     = '0;
                    word_next  = '0;
                    state_next = CENTER;
                end
            end
            CENTER: begin
                c_next = bus.res_di;
                k_next = '0;
                if (bus.res_di == 8'd0) begin
                    fin = 1'b1;
                end else begin
                    state_next = NBR;
                end
            end
            NBR: begin
                if (nbr_val > c_reg) begin
                    fin = 1'b1;
                end else if (k_reg == 3'd7) begin
                    fin  = 1'b1;
                    flag = 1'b1;
                end else begin
                    k_next = k_reg + 3'd1;
                end
            end
            WRITE: begin
                if (p_reg == 14'd16383) begin
                    state_next = FIN;
                end else begin
                    p_next     = p_reg + 14'd1;
                    state_next = CENTER;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Shifting left leaves the first pixel of each word at bit 15 after 16 shifts.
        if (fin) begin
            word_next = {word_reg[14:0], flag};
            if (p_reg[3:0] == 4'd15) begin
                state_next = WRITE;
            end else begin
                p_next     = p_reg + 14'd1;
                state_next = CENTER;
            end
        end
    end

    assign bus.res_rd   = (state_reg == CENTER) || ((state_reg == NBR) && nbr_in);
    assign bus.res_addr = (state_reg == NBR) ? nbr_addr : p_reg;
    assign bus.skl_wr   = (state_reg == WRITE);
    assign bus.skl_addr = p_reg[13:4];
    assign bus.skl_do   = (state_reg == WRITE) ? word_reg : 16'h0000;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == FIN);

`ifdef DT_RIDGE_CNT_EN
    logic [14:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if ((state_reg == IDLE) && bus.start) begin
            cnt_reg <= '0;
        end else if (fin && flag) begin
            cnt_reg <= cnt_reg + 15'd1;
        end
    end

    assign bus.ridge_cnt = cnt_reg;
`else
    assign bus.ridge_cnt = '0;
`endif
endmodule

// File: tb/tb_dt_ridge_pack.sv
// Bench for dt_ridge_pack: table of placed features with hand-derived words, a random
// patch, and a mid-scan reset/restart, all traced cycle by cycle against a pixel-level model.
module tb_dt_ridge_pack;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    dt_ridge_pack_if bus();
    dt_ridge_pack dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

`ifdef DT_RIDGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [7:0] ram [16384];
    assign bus.res_di = ram[bus.res_addr];

    typedef struct {
        logic        rd;
        logic [13:0] addr;
        logic        wr;
        logic [9:0]  waddr;
        logic [15:0] wdata;
        logic        done;
    } cyc_t;

    typedef struct {
        int          x0, y0, w, h, v;
        int          word;
        logic [15:0] val;
    } vec_t;

    cyc_t        exp_q[$];
    int          exp_cnt;
    logic [15:0] got_word [1024];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    function automatic int cnt_req(input int n);
        return CNT_EN ? n : 0;
    endfunction

    function automatic void push(input logic rd, input int addr, input logic wr,
                                 input int waddr, input logic [15:0] wdata, input logic done);
        cyc_t e;
        e.rd    = rd;
        e.addr  = 14'(addr);
        e.wr    = wr;
        e.waddr = 10'(waddr);
        e.wdata = wdata;
        e.done  = done;
        exp_q.push_back(e);
    endfunction

    // Walks the image pixel by pixel, producing the expected bus activity of every cycle.
    function automatic void build_model();
        int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        exp_q.delete();
        exp_cnt = 0;
        for (int w = 0; w < 1024; w++) begin
            logic [15:0] word;
            word = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                int p, x, y, c;
                bit ridge;
                p = w * 16 + b;
                x = p % 128;
                y = p / 128;
                c = int'(ram[p]);
                push(1'b1, p, 1'b0, 0, 16'h0, 1'b0);
                ridge = (c != 0);
                if (c != 0) begin
                    for (int k = 0; k < 8; k++) begin
                        int nx, ny, v;
                        bit inb;
                        nx  = x + dxs[k];
                        ny  = y + dys[k];
                        inb = (nx >= 0) && (nx < 128) && (ny >= 0) && (ny < 128);
                        v   = inb ? int'(ram[ny * 128 + nx]) : 0;
                        push(inb, inb ? ny * 128 + nx : 0, 1'b0, 0, 16'h0, 1'b0);
                        if (v > c) begin
                            ridge = 1'b0;
                            break;
                        end
                    end
                end
                if (ridge) begin
                    word[15 - b] = 1'b1;
                    exp_cnt++;
                end
            end
            push(1'b0, 0, 1'b1, w, word, 1'b0);
        end
        push(1'b0, 0, 1'b0, 0, 16'h0, 1'b1);
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < 16384; i++) ram[i] = 8'd0;
    endtask

    task automatic run_scan(input string name, input int restart_at, output int dut_cycles);
        int    bad, writes, dones, done_idx, n;
        string first_bad;
        bad = 0; writes = 0; dones = 0; done_idx = -1; first_bad = "";
        build_model();
        n = exp_q.size();
        for (int i = 0; i < 1024; i++) got_word[i] = 16'hDEAD;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int i = 0; i < n + 64; i++) begin
            @(negedge clk);
            bus.start = (i == restart_at);
            if (bus.skl_wr === 1'b1) begin
                writes++;
                got_word[bus.skl_addr] = bus.skl_do;
            end
            if (bus.done === 1'b1) begin
                dones++;
                if (done_idx < 0) done_idx = i;
            end
            if (i < n) begin
                cyc_t e;
                logic ok;
                e  = exp_q[i];
                ok = (bus.res_rd === e.rd) && (!e.rd || (bus.res_addr === e.addr)) &&
                     (bus.skl_wr === e.wr) &&
                     (!e.wr || ((bus.skl_addr === e.waddr) && (bus.skl_do === e.wdata))) &&
                     (bus.done === e.done) && (e.done || (bus.busy === 1'b1));
                if (!ok) begin
                    if (bad == 0)
                        first_bad = $sformatf({"cycle %0d got rd=%b addr=%0d wr=%b waddr=%0d wdata=%h done=%b busy=%b,",
                                               " required rd=%b addr=%0d wr=%b waddr=%0d wdata=%h done=%b"},
                                              i, bus.res_rd, bus.res_addr, bus.skl_wr, bus.skl_addr, bus.skl_do,
                                              bus.done, bus.busy, e.rd, e.addr, e.wr, e.waddr, e.wdata, e.done);
                    bad++;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL trace_%s: %0d mismatching cycles, first at %s", name, bad, first_bad);
        end
        chk({name, "_cycles"}, done_idx + 1, n);
        chk({name, "_writes"}, writes, 1024);
        chk({name, "_done_pulses"}, dones, 1);
        chk({name, "_ridge_cnt"}, bus.ridge_cnt, cnt_req(exp_cnt));
        chk({name, "_busy_after"}, bus.busy, 0);
        dut_cycles = done_idx + 1;
        $display("scan %s: %0d cycles (model %0d), %0d writes, %0d ridge pixels (model)",
                 name, dut_cycles, n, writes, exp_cnt);
    endtask

    initial begin
        vec_t vecs[11];
        int   cyc;
        int   found;
        int   wr_in_reset;

        // {x0, y0, w, h, value, word to inspect, required word}; rectangles paint in order.
        vecs[0]  = '{10, 10, 1, 1, 1, 80,   16'h0020};
        vecs[1]  = '{0,  0,  0, 0, 0, 81,   16'h0000};
        vecs[2]  = '{20, 5,  3, 3, 1, 41,   16'h0E00};
        vecs[3]  = '{0,  0,  0, 0, 0, 49,   16'h0E00};
        vecs[4]  = '{0,  0,  0, 0, 0, 57,   16'h0E00};
        vecs[5]  = '{38, 38, 5, 5, 1, 314,  16'h0000};
        vecs[6]  = '{39, 39, 3, 3, 2, 330,  16'h0000};
        vecs[7]  = '{40, 40, 1, 1, 3, 322,  16'h0080};
        vecs[8]  = '{0,  0,  1, 1, 1, 0,    16'h8000};
        vecs[9]  = '{127,127,1, 1, 1, 1023, 16'h0001};
        vecs[10] = '{0,  0,  0, 0, 0, 1016, 16'h0000};

        bus.start = 1'b0;
        clear_ram();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res_rd", bus.res_rd, 0);
        chk("rst_res_addr", bus.res_addr, 0);
        chk("rst_skl_wr", bus.skl_wr, 0);
        chk("rst_skl_addr", bus.skl_addr, 0);
        chk("rst_skl_do", bus.skl_do, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ridge_cnt", bus.ridge_cnt, 0);
        reset = 1'b1;

        // Feature map: isolated pixel, plateau, pyramid, two corners.
        foreach (vecs[i])
            for (int yy = vecs[i].y0; yy < vecs[i].y0 + vecs[i].h; yy++)
                for (int xx = vecs[i].x0; xx < vecs[i].x0 + vecs[i].w; xx++)
                    ram[yy * 128 + xx] = 8'(vecs[i].v);
        run_scan("features", -1, cyc);
        chk("features_ridge_cnt_const", bus.ridge_cnt, cnt_req(13));
        foreach (vecs[i]) begin
            chk($sformatf("word_%0d", vecs[i].word), got_word[vecs[i].word], vecs[i].val);
            $display("vector %0d: word %0d = %h (required %h)", i, vecs[i].word, got_word[vecs[i].word], vecs[i].val);
        end
        repeat (3) @(negedge clk);
        chk("features_ridge_cnt_hold", bus.ridge_cnt, cnt_req(exp_cnt));

        // Random low-valued patch: lots of ties and early exits.
        clear_ram();
        for (int yy = 72; yy < 108; yy++)
            for (int xx = 0; xx < 128; xx++)
                if ($urandom_range(3) == 0) ram[yy * 128 + xx] = 8'($urandom_range(3, 1));
        run_scan("random", -1, cyc);

        // Zero map: reset in the middle of word 300, then restart with a stray second start.
        clear_ram();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 8000 && found == 0; i++) begin
            @(negedge clk);
            if (bus.res_rd === 1'b1 && bus.res_addr === 14'd4803) found = 1;
        end
        chk("reset_reach_word300", found, 1);
        reset = 1'b0;
        #1;
        chk("midrst_res_rd", bus.res_rd, 0);
        chk("midrst_res_addr", bus.res_addr, 0);
        chk("midrst_skl_wr", bus.skl_wr, 0);
        chk("midrst_skl_do", bus.skl_do, 0);
        chk("midrst_skl_addr", bus.skl_addr, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ridge_cnt", bus.ridge_cnt, 0);
        wr_in_reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.skl_wr !== 1'b0 || bus.busy !== 1'b0) wr_in_reset++;
        end
        chk("midrst_quiet", wr_in_reset, 0);
        reset = 1'b1;
        run_scan("restart", 100, cyc);
        chk("restart_cycles_const", cyc, 17409);
        chk("restart_ridge_cnt", bus.ridge_cnt, 0);
        chk("restart_word0", got_word[0], 16'h0000);
        chk("restart_word1023", got_word[1023], 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
